// File: rtl/lcd_ctrl.sv
// HD44780 write engine: runs the power-on init by itself, then turns each accepted host word
// into one setup / EN-pulse / hold / execution-wait bus cycle on the LCD pins.
module lcd_ctrl #(
    parameter int POWERUP_CYC = 750000,
    parameter int SETUP_CYC   = 2,
    parameter int EN_HIGH_CYC = 25,
    parameter int HOLD_CYC    = 2,
    parameter int EXEC_CYC    = 2000,
    parameter int CLEAR_CYC   = 82000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] lcd_word_i,
    input  logic        wr_valid_i,
    output logic        wr_ready_o,
    output logic        busy_o,
    output logic        init_done_o,
    output logic        lcd_on_o,
    output logic        lcd_rs_o,
    output logic        lcd_rw_o,
    output logic        lcd_en_o,
    output logic [7:0]  lcd_data_o
);

    localparam int CNT_MAX = (POWERUP_CYC > CLEAR_CYC) ? POWERUP_CYC : CLEAR_CYC;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        PWR_WAIT,
        INIT_LOAD,
        IDLE,
        SETUP,
        EN_HI,
        HOLD,
        EXEC_WAIT
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [2:0]      idx_q;
    logic            on_q;
    logic            rs_q;
    logic            en_q;
    logic [7:0]      data_q;
    logic            ready_q;
    logic            busy_q;
    logic            done_q;

    logic [CW-1:0]   exec_ld_d;
    logic [7:0]      init_cmd_d;
    logic            accept_d;
    logic            unused_word_bits;

    assign unused_word_bits = ^{lcd_word_i[30:11], lcd_word_i[9:8]};

    always_comb begin
        exec_ld_d = CW'(EXEC_CYC - 1);
        if (!rs_q && (data_q == 8'h01 || data_q == 8'h02 || data_q == 8'h03)) begin
            exec_ld_d = CW'(CLEAR_CYC - 1);
        end
    end

    always_comb begin
        init_cmd_d = 8'h38;
        case (idx_q)
            3'd3:    init_cmd_d = 8'h0C;
            3'd4:    init_cmd_d = 8'h01;
            3'd5:    init_cmd_d = 8'h06;
            default: init_cmd_d = 8'h38;
        endcase
    end

    assign accept_d = wr_valid_i && ready_q;

    // The cycle spent in IDLE or INIT_LOAD is the last cycle of the execution wait, so the
    // next word can be accepted on the edge that ends the wait: no dead cycle between transfers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= PWR_WAIT;
            cnt_q   <= '0;
            idx_q   <= '0;
            on_q    <= 1'b0;
            rs_q    <= 1'b0;
            en_q    <= 1'b0;
            data_q  <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                PWR_WAIT: begin
                    if (!on_q) begin
                        on_q  <= 1'b1;
                        cnt_q <= CW'(POWERUP_CYC - 1);
                    end else if (cnt_q == '0) begin
                        state_q <= INIT_LOAD;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                INIT_LOAD: begin
                    rs_q    <= 1'b0;
                    data_q  <= init_cmd_d;
                    cnt_q   <= CW'(SETUP_CYC - 1);
                    state_q <= SETUP;
                end
                IDLE: begin
                    if (accept_d) begin
                        on_q    <= lcd_word_i[31];
                        rs_q    <= lcd_word_i[10];
                        data_q  <= lcd_word_i[7:0];
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        cnt_q   <= CW'(SETUP_CYC - 1);
                        state_q <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt_q == '0) begin
                        en_q    <= 1'b1;
                        cnt_q   <= CW'(EN_HIGH_CYC - 1);
                        state_q <= EN_HI;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                EN_HI: begin
                    if (cnt_q == '0) begin
                        en_q    <= 1'b0;
                        cnt_q   <= CW'(HOLD_CYC - 1);
                        state_q <= HOLD;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                HOLD: begin
                    if (cnt_q == '0) begin
                        cnt_q   <= exec_ld_d;
                        state_q <= EXEC_WAIT;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                EXEC_WAIT: begin
                    if (cnt_q <= CW'(1)) begin
                        if (done_q || idx_q == 3'd5) begin
                            done_q  <= 1'b1;
                            ready_q <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            idx_q   <= idx_q + 3'd1;
                            state_q <= INIT_LOAD;
                        end
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                default: state_q <= PWR_WAIT;
            endcase
        end
    end

    assign wr_ready_o  = ready_q;
    assign busy_o      = busy_q;
    assign init_done_o = done_q;
    assign lcd_on_o    = on_q;
    assign lcd_rs_o    = rs_q;
    assign lcd_rw_o    = 1'b0;
    assign lcd_en_o    = en_q;
    assign lcd_data_o  = data_q;

endmodule
